// File: rtl/seq_mult_unit.sv
// Sequential shift-add multiplier with its own load/add/shift/fix controller.
// Signed mode multiplies magnitudes and negates the result at the end.
module seq_mult_unit #(
  parameter int BIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [BIT-1:0]     I_B,
  input  logic [BIT-1:0]     I_Q,
  output logic [2*BIT-1:0]   product,
  output logic               busy,
  output logic               done
);

  localparam int PW = $clog2(BIT + 1);

  typedef enum logic [1:0] {IDLE, ADD, SHIFT, FIX} state_t;

  state_t          state_q;
  logic [BIT-1:0]  b_q, q_q, a_q;
  logic            c_q, n_q;
  logic [PW-1:0]   p_q;

  logic [BIT-1:0]  magB_d, magQ_d;
  logic [BIT:0]    sum_d;

  // The magnitude of the most negative value still fits when read as unsigned.
  assign magB_d = (sgn && I_B[BIT-1]) ? -I_B : I_B;
  assign magQ_d = (sgn && I_Q[BIT-1]) ? -I_Q : I_Q;
  assign sum_d  = {1'b0, a_q} + {1'b0, b_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      q_q     <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      p_q     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            b_q     <= magB_d;
            q_q     <= magQ_d;
            a_q     <= '0;
            c_q     <= 1'b0;
            p_q     <= PW'(BIT);
            n_q     <= sgn & (I_B[BIT-1] ^ I_Q[BIT-1]);
            busy    <= 1'b1;
            state_q <= ADD;
          end
        end
        ADD: begin
          if (q_q[0]) begin
            {c_q, a_q} <= sum_d;
          end
          p_q     <= p_q - PW'(1);
          state_q <= SHIFT;
        end
        SHIFT: begin
          {c_q, a_q, q_q} <= {1'b0, c_q, a_q, q_q[BIT-1:1]};
          state_q         <= (p_q == '0) ? FIX : ADD;
        end
        FIX: begin
          product <= n_q ? -{a_q, q_q} : {a_q, q_q};
          done    <= 1'b1;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
